// File: rtl/pll_md_sequencer.sv
// -----------------------------------------------------------------------------
// pll_md_sequencer
//   Brings the PLL up and reconfigures it at runtime through the MD port.
//   The PLL is held in reset while the three divider registers (feedback,
//   input, output) are written with a WRITE / auto-increment pair each. Reset
//   is then released, and lock is qualified with a debounce counter and a
//   timeout. A timeout triggers a retry, and FAIL is entered once the retry
//   budget is used up. System logic changes the multiplier with a level
//   request and ack handshake.
//
// Ports
//   i_mdclk        sole clock, rising edge
//   i_reset        asynchronous, active-high reset
//   i_pll_lock     raw PLL lock (asynchronous to i_mdclk)
//   o_pll_rst      PLL reset, active-high
//   o_md_opc       MD opcode: 00 NOP, 01 WRITE
//   o_md_ainc      MD address auto-increment strobe
//   o_md_wdi       MD write data
//   i_md_rdo       MD read data (reserved, unused)
//   i_reconf_req   level request to reprogram the multiplier (held until ack)
//   i_reconf_mult  requested multiplier minus 1
//   o_reconf_ack   one-cycle pulse when a request is consumed
//   o_lock         qualified lock
//   o_busy         high in every state except LOCKED and FAIL
//   o_fail         high in FAIL
//   o_retry_cnt    timeouts since the last successful lock
// -----------------------------------------------------------------------------
module pll_md_sequencer #(
  parameter int MULTI_FAC    = 30,
  parameter int IDIV         = 1,
  parameter int ODIV         = 2,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 256,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int MAX_RETRY    = 3
) (
  input  logic       i_mdclk,
  input  logic       i_reset,
  input  logic       i_pll_lock,
  output logic       o_pll_rst,
  output logic [1:0] o_md_opc,
  output logic       o_md_ainc,
  output logic [7:0] o_md_wdi,
  input  logic [7:0] i_md_rdo,
  input  logic       i_reconf_req,
  input  logic [7:0] i_reconf_mult,
  output logic       o_reconf_ack,
  output logic       o_lock,
  output logic       o_busy,
  output logic       o_fail,
  output logic [1:0] o_retry_cnt
);

  localparam int RCW = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)       : 1;
  localparam int SW  = $clog2(LOCK_STABLE + 1);
  localparam int TW  = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_CYCLES - 1);
  localparam logic [SW-1:0]  STAB_MAX  = SW'(LOCK_STABLE);
  localparam logic [TW-1:0]  TO_MAX    = TW'(LOCK_TIMEOUT);
  localparam logic [1:0]     RETRY_MAX = 2'(MAX_RETRY);
  localparam logic [7:0]     MULT_INIT = 8'(MULTI_FAC - 1);
  localparam logic [7:0]     IDIV_M1   = 8'(IDIV - 1);
  localparam logic [7:0]     ODIV_M1   = 8'(ODIV - 1);

  typedef enum logic [2:0] {
    S_RST_HOLD  = 3'd0,
    S_CFG_WR    = 3'd1,
    S_CFG_INC   = 3'd2,
    S_RELEASE   = 3'd3,
    S_WAIT_LOCK = 3'd4,
    S_LOCKED    = 3'd5,
    S_FAIL      = 3'd6
  } state_t;

  state_t         r_state, w_state_next;
  logic [1:0]     r_idx, w_idx_next;
  logic [RCW-1:0] r_rst_cnt, w_rst_cnt_next;
  logic [SW-1:0]  r_stab_cnt, w_stab_cnt_next, w_stab_inc;
  logic [TW-1:0]  r_to_cnt, w_to_cnt_next, w_to_inc;
  logic [7:0]     r_mult, w_mult_next;
  logic [1:0]     r_retry, w_retry_next;
  logic           w_take_req;
  logic           r_sync1, r_lock_s;

  // Registered outputs and the values they load on the next edge
  logic           r_pll_rst, w_pll_rst_next;
  logic [1:0]     r_md_opc, w_md_opc_next;
  logic           r_md_ainc, w_md_ainc_next;
  logic [7:0]     r_md_wdi, w_md_wdi_next;
  logic           r_ack, w_ack_next;
  logic           r_lock, w_lock_next;
  logic           r_busy, w_busy_next;
  logic           r_fail, w_fail_next;
  logic [7:0]     w_cfg_data;

  // Read data is a reserved input; it only feeds this sink.
  logic w_md_rdo_unused;
  assign w_md_rdo_unused = ^i_md_rdo;

  // State register: FSM state, datapath counters, lock synchronizer, outputs
  always_ff @(posedge i_mdclk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_RST_HOLD;
      r_idx      <= 2'd0;
      r_rst_cnt  <= '0;
      r_stab_cnt <= '0;
      r_to_cnt   <= '0;
      r_mult     <= MULT_INIT;
      r_retry    <= 2'd0;
      r_sync1    <= 1'b0;
      r_lock_s   <= 1'b0;
      r_pll_rst  <= 1'b1;
      r_md_opc   <= 2'b00;
      r_md_ainc  <= 1'b0;
      r_md_wdi   <= 8'h00;
      r_ack      <= 1'b0;
      r_lock     <= 1'b0;
      r_busy     <= 1'b1;
      r_fail     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_rst_cnt  <= w_rst_cnt_next;
      r_stab_cnt <= w_stab_cnt_next;
      r_to_cnt   <= w_to_cnt_next;
      r_mult     <= w_mult_next;
      r_retry    <= w_retry_next;
      r_sync1    <= i_pll_lock;
      r_lock_s   <= r_sync1;
      r_pll_rst  <= w_pll_rst_next;
      r_md_opc   <= w_md_opc_next;
      r_md_ainc  <= w_md_ainc_next;
      r_md_wdi   <= w_md_wdi_next;
      r_ack      <= w_ack_next;
      r_lock     <= w_lock_next;
      r_busy     <= w_busy_next;
      r_fail     <= w_fail_next;
    end
  end

  assign w_stab_inc = r_stab_cnt + SW'(1);
  assign w_to_inc   = r_to_cnt + TW'(1);

  // Next-state logic
  always_comb begin
    w_state_next    = r_state;
    w_idx_next      = r_idx;
    w_rst_cnt_next  = r_rst_cnt;
    w_stab_cnt_next = r_stab_cnt;
    w_to_cnt_next   = r_to_cnt;
    w_mult_next     = r_mult;
    w_retry_next    = r_retry;
    w_take_req      = 1'b0;
    case (r_state)
      S_RST_HOLD: begin
        // The PLL clears its MD address pointer while in reset, so every
        // programming pass starts at address 0.
        if (r_rst_cnt == RST_LAST) begin
          w_rst_cnt_next = '0;
          w_idx_next     = 2'd0;
          w_state_next   = S_CFG_WR;
        end else begin
          w_rst_cnt_next = r_rst_cnt + RCW'(1);
        end
      end
      S_CFG_WR: w_state_next = S_CFG_INC;
      S_CFG_INC: begin
        if (r_idx == 2'd2) begin
          w_state_next = S_RELEASE;
        end else begin
          w_idx_next   = r_idx + 2'd1;
          w_state_next = S_CFG_WR;
        end
      end
      S_RELEASE: begin
        w_stab_cnt_next = '0;
        w_to_cnt_next   = '0;
        w_state_next    = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        w_stab_cnt_next = r_lock_s ? w_stab_inc : '0;
        w_to_cnt_next   = w_to_inc;
        // Lock qualification is tested first so it wins a tie with timeout.
        if (r_lock_s && (w_stab_inc == STAB_MAX)) begin
          w_retry_next = 2'd0;
          w_state_next = S_LOCKED;
        end else if (w_to_inc == TO_MAX) begin
          if (r_retry < RETRY_MAX) begin
            w_retry_next = r_retry + 2'd1;
            w_state_next = S_RST_HOLD;
          end else begin
            w_state_next = S_FAIL;
          end
        end
      end
      S_LOCKED: begin
        // Lock loss takes priority; a concurrent request stays pending.
        if (!r_lock_s) begin
          w_state_next = S_RST_HOLD;
        end else if (i_reconf_req) begin
          w_take_req   = 1'b1;
          w_mult_next  = i_reconf_mult;
          w_state_next = S_RST_HOLD;
        end
      end
      S_FAIL: begin
        if (i_reconf_req) begin
          w_take_req   = 1'b1;
          w_mult_next  = i_reconf_mult;
          w_retry_next = 2'd0;
          w_state_next = S_RST_HOLD;
        end
      end
      default: w_state_next = S_RST_HOLD;
    endcase
  end

  // Divider table entry addressed by the index used in the next cycle
  always_comb begin
    case (w_idx_next)
      2'd0:    w_cfg_data = r_mult;
      2'd1:    w_cfg_data = IDIV_M1;
      2'd2:    w_cfg_data = ODIV_M1;
      default: w_cfg_data = r_mult;
    endcase
  end

  // Output logic: decoded from the upcoming state, so the registered outputs
  // line up with the state they belong to.
  always_comb begin
    w_pll_rst_next = 1'b0;
    w_md_opc_next  = 2'b00;
    w_md_ainc_next = 1'b0;
    w_md_wdi_next  = r_md_wdi;
    w_ack_next     = w_take_req;
    w_lock_next    = 1'b0;
    w_busy_next    = 1'b1;
    w_fail_next    = 1'b0;
    case (w_state_next)
      S_RST_HOLD: w_pll_rst_next = 1'b1;
      S_CFG_WR: begin
        w_pll_rst_next = 1'b1;
        w_md_opc_next  = 2'b01;
        w_md_wdi_next  = w_cfg_data;
      end
      S_CFG_INC: begin
        w_pll_rst_next = 1'b1;
        w_md_ainc_next = 1'b1;
      end
      S_RELEASE, S_WAIT_LOCK: w_pll_rst_next = 1'b0;
      S_LOCKED: begin
        w_lock_next = 1'b1;
        w_busy_next = 1'b0;
      end
      S_FAIL: begin
        w_pll_rst_next = 1'b1;
        w_busy_next    = 1'b0;
        w_fail_next    = 1'b1;
      end
      default: w_pll_rst_next = 1'b1;
    endcase
  end

  assign o_pll_rst    = r_pll_rst;
  assign o_md_opc     = r_md_opc;
  assign o_md_ainc    = r_md_ainc;
  assign o_md_wdi     = r_md_wdi;
  assign o_reconf_ack = r_ack;
  assign o_lock       = r_lock;
  assign o_busy       = r_busy;
  assign o_fail       = r_fail;
  assign o_retry_cnt  = r_retry;

endmodule

// File: tb/tb_pll_md_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_md_sequencer
//   Directed sequence with randomized multipliers and lock timing. Expected
//   values come from the sequencing rules: the divider table, a hold of
//   RST_CYCLES cycles, 2-flop sync latency, LOCK_STABLE debounce, LOCK_TIMEOUT
//   window and the retry budget.
// -----------------------------------------------------------------------------
module tb_pll_md_sequencer;

  localparam int MULTI_FAC    = 30;
  localparam int IDIV         = 1;
  localparam int ODIV         = 2;
  localparam int RST_CYCLES   = 4;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 100;
  localparam int MAX_RETRY    = 2;
  localparam int SYNC_LAT     = 2;

  logic       mdclk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b1;
  logic       pll_rst;
  logic [1:0] md_opc;
  logic       md_ainc;
  logic [7:0] md_wdi;
  logic [7:0] md_rdo = 8'h00;
  logic       reconf_req = 1'b0;
  logic [7:0] reconf_mult = 8'h00;
  logic       reconf_ack;
  logic       lock;
  logic       busy;
  logic       fail;
  logic [1:0] retry_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  pll_md_sequencer #(
    .MULTI_FAC(MULTI_FAC), .IDIV(IDIV), .ODIV(ODIV), .RST_CYCLES(RST_CYCLES),
    .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .i_mdclk(mdclk), .i_reset(reset), .i_pll_lock(pll_lock),
    .o_pll_rst(pll_rst), .o_md_opc(md_opc), .o_md_ainc(md_ainc),
    .o_md_wdi(md_wdi), .i_md_rdo(md_rdo), .i_reconf_req(reconf_req),
    .i_reconf_mult(reconf_mult), .o_reconf_ack(reconf_ack), .o_lock(lock),
    .o_busy(busy), .o_fail(fail), .o_retry_cnt(retry_cnt)
  );

  always #5 mdclk = ~mdclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mdclk);
    #1;
  endtask

  // Counts reset-hold cycles starting with the current sample.
  task automatic expect_hold(input string tag, input int exp_len);
    int   n;
    logic clean;
    n = 0;
    clean = 1'b1;
    while (md_opc !== 2'b01 && n < 200) begin
      if (pll_rst !== 1'b1 || md_ainc !== 1'b0 || lock !== 1'b0 || busy !== 1'b1)
        clean = 1'b0;
      n++;
      tick();
    end
    check({tag, "_hold_len"}, n, exp_len);
    check({tag, "_hold_outs"}, {31'd0, clean}, 1);
  endtask

  // Current sample must be the first WRITE; ends on the release cycle.
  task automatic check_pass(input string tag, input logic [7:0] mult);
    logic [7:0] tbl [3];
    tbl[0] = mult;
    tbl[1] = 8'(IDIV - 1);
    tbl[2] = 8'(ODIV - 1);
    for (int k = 0; k < 3; k++) begin
      check({tag, "_wr"}, {20'd0, md_opc, md_ainc, md_wdi, pll_rst}, {20'd0, 2'b01, 1'b0, tbl[k], 1'b1});
      tick();
      check({tag, "_inc"}, {20'd0, md_opc, md_ainc, md_wdi, pll_rst}, {20'd0, 2'b00, 1'b1, tbl[k], 1'b1});
      tick();
    end
    check({tag, "_release"}, {27'd0, md_opc, md_ainc, pll_rst, busy, lock},
          {27'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic expect_lock(input string tag, input int exp_ticks);
    int   n;
    logic acked;
    n = 0;
    acked = 1'b0;
    while (lock !== 1'b1 && n < 2000) begin
      tick();
      n++;
      if (reconf_ack === 1'b1) acked = 1'b1;
    end
    check({tag, "_lock_latency"}, n, exp_ticks);
    check({tag, "_no_ack_wait"}, {31'd0, acked}, 0);
    check({tag, "_locked_outs"}, {27'd0, busy, fail, pll_rst, retry_cnt}, 0);
  endtask

  task automatic expect_timeout(input string tag, input logic [1:0] exp_retry, input logic exp_fail);
    int n;
    n = 0;
    while (pll_rst !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_timeout_len"}, n, LOCK_TIMEOUT + 1);
    check({tag, "_timeout_outs"}, {25'd0, fail, busy, retry_cnt, lock, md_opc},
          {25'd0, exp_fail, ~exp_fail, exp_retry, 1'b0, 2'b00});
  endtask

  // Raw lock low (1 cycle when pulse=1): lock drops after sync + 1 edge.
  task automatic lock_drop(input string tag, input logic pulse);
    int n;
    pll_lock = 1'b0;
    tick();
    n = 1;
    if (pulse) pll_lock = 1'b1;
    while (lock === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_drop_latency"}, n, SYNC_LAT + 1);
    check({tag, "_drop_outs"}, {28'd0, pll_rst, reconf_ack, retry_cnt}, {28'd0, 1'b1, 1'b0, 2'd0});
  endtask

  // Current sample is LOCKED with the request raised; consumes the ack.
  task automatic take_ack(input string tag, input logic drop_req);
    tick();
    check({tag, "_ack"}, {29'd0, reconf_ack, lock, busy}, {29'd0, 1'b1, 1'b0, 1'b1});
    if (drop_req) begin
      reconf_req = 1'b0;
      tick();
      check({tag, "_ack_single"}, {31'd0, reconf_ack}, 0);
    end
  endtask

  initial begin
    logic [7:0] m1, m2, m3;
    int d;
    m1 = 8'($urandom_range(0, 255)); if (m1 == 8'h1D) m1 = 8'h13;
    m2 = 8'($urandom_range(0, 255)); if (m2 == 8'h1D) m2 = 8'h55;
    m3 = 8'($urandom_range(0, 255)); if (m3 == 8'h1D) m3 = 8'hA7;

    // Power-up with lock high from t0
    tick();
    tick();
    check("reset_outs", {18'd0, pll_rst, md_opc, md_ainc, md_wdi, reconf_ack, lock, busy, fail, retry_cnt},
          {18'd0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0});
    reset = 1'b0;
    expect_hold("boot", RST_CYCLES);
    check_pass("boot", 8'(MULTI_FAC - 1));
    expect_lock("boot", LOCK_STABLE + 1);

    // Reconfiguration with a random multiplier, released right after ack
    reconf_mult = m1;
    reconf_req  = 1'b1;
    take_ack("reconf1", 1'b1);
    expect_hold("reconf1", RST_CYCLES - 1);
    check_pass("reconf1", m1);
    expect_lock("reconf1", LOCK_STABLE + 1);

    // Request held past the ack: served again at the next lock
    reconf_mult = m2;
    reconf_req  = 1'b1;
    take_ack("reconf2a", 1'b0);
    expect_hold("reconf2a", RST_CYCLES);
    check_pass("reconf2a", m2);
    expect_lock("reconf2a", LOCK_STABLE + 1);
    take_ack("reconf2b", 1'b1);
    expect_hold("reconf2b", RST_CYCLES - 1);
    check_pass("reconf2b", m2);
    expect_lock("reconf2b", LOCK_STABLE + 1);

    // One-cycle lock glitch forces a full reprogram with the same multiplier
    lock_drop("glitch", 1'b1);
    expect_hold("glitch", RST_CYCLES);
    check_pass("glitch", m2);
    expect_lock("glitch", LOCK_STABLE + 1);

    // Lock lost; request raised during WAIT_LOCK; debounce restart at 7 of 8
    lock_drop("loss", 1'b0);
    expect_hold("loss", RST_CYCLES);
    check_pass("loss", m2);
    reconf_mult = m3;
    reconf_req  = 1'b1;
    d = $urandom_range(0, 20);
    repeat (d) tick();
    pll_lock = 1'b1;
    repeat (LOCK_STABLE - 1) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    expect_lock("debounce", SYNC_LAT + LOCK_STABLE);
    take_ack("waitreq", 1'b1);
    expect_hold("waitreq", RST_CYCLES - 1);

    // Reset asserted while writing divider index 1
    check("abort_wr0", {22'd0, md_opc, md_wdi}, {22'd0, 2'b01, m3});
    tick();
    tick();
    check("abort_wr1", {22'd0, md_opc, md_wdi}, {22'd0, 2'b01, 8'(IDIV - 1)});
    reset = 1'b1;
    #1;
    check("abort_outs", {18'd0, pll_rst, md_opc, md_ainc, md_wdi, reconf_ack, lock, busy, fail, retry_cnt},
          {18'd0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0});
    tick();
    tick();
    reset = 1'b0;
    expect_hold("restart", RST_CYCLES);
    check_pass("restart", 8'(MULTI_FAC - 1));
    expect_lock("restart", LOCK_STABLE + 1);

    // Lock stuck low: retries then FAIL
    lock_drop("stuck", 1'b0);
    for (int r = 0; r <= MAX_RETRY; r++) begin
      expect_hold("retry", RST_CYCLES);
      check_pass("retry", 8'(MULTI_FAC - 1));
      if (r < MAX_RETRY) expect_timeout("retry", 2'(r + 1), 1'b0);
      else               expect_timeout("fail", 2'(MAX_RETRY), 1'b1);
    end
    repeat (5) tick();
    check("fail_stays", {27'd0, fail, pll_rst, busy, retry_cnt}, {27'd0, 1'b1, 1'b1, 1'b0, 2'(MAX_RETRY)});

    // Exit FAIL through a reconfiguration request
    pll_lock    = 1'b1;
    reconf_mult = 8'h1D;
    reconf_req  = 1'b1;
    tick();
    check("fail_exit", {27'd0, reconf_ack, fail, busy, retry_cnt}, {27'd0, 1'b1, 1'b0, 1'b1, 2'd0});
    reconf_req = 1'b0;
    tick();
    check("fail_exit_single", {31'd0, reconf_ack}, 0);
    expect_hold("fail_exit", RST_CYCLES - 1);
    check_pass("fail_exit", 8'h1D);
    expect_lock("fail_exit", LOCK_STABLE + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_md_sequencer.md
Name: pll_md_sequencer

Overview:
Owns bring-up and runtime reconfiguration of the on-chip PLL through its MD (dynamic-config) port. Holds the PLL in reset and programs the divider registers (feedback, input, output) through the MD opcode/auto-increment interface. It then releases reset and qualifies lock with debounce and timeout, retrying on timeout. Sits between the clock wrapper and the PLL primitive, and accepts multiplier-change requests from system logic.

Parameters:
MULTI_FAC, 30, power-up feedback multiplier (1..256); written to MD addr 0 as MULTI_FAC-1
IDIV, 1, input divider (1..256); written to MD addr 1 as IDIV-1
ODIV, 2, output divider (1..256); written to MD addr 2 as ODIV-1
RST_CYCLES, 16, mdclk cycles pll_rst is held before programming starts (>=1)
LOCK_STABLE, 256, consecutive synchronized lock-high cycles required before lock asserts (>=1)
LOCK_TIMEOUT, 65535, max mdclk cycles in WAIT_LOCK before a retry (>=LOCK_STABLE)
MAX_RETRY, 3, timeout retries before FAIL (0..3)

Ports:
mdclk  in  1  sole clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
pll_lock  in  1  raw PLL lock, asynchronous to mdclk
pll_rst  out  1  PLL reset, active-high
md_opc  out  2  MD opcode: 00 NOP, 01 WRITE (10/11 never driven)
md_ainc  out  1  MD address auto-increment strobe
md_wdi  out  8  MD write data
md_rdo  in  8  MD read data; captured into nothing, reserved
reconf_req  in  1  level request to reprogram multiplier; held until ack
reconf_mult  in  8  requested multiplier minus 1 (0x00 => x1, 0xFF => x256)
reconf_ack  out  1  one-cycle pulse: request consumed
lock  out  1  qualified lock
busy  out  1  high in every state except LOCKED and FAIL
fail  out  1  high in FAIL
retry_cnt  out  2  timeouts since last successful lock

Behaviour:
- Reset (async, any state): state=RST_HOLD, pll_rst=1, md_opc=00, md_ainc=0, md_wdi=0, reconf_ack=0, lock=0, busy=1, fail=0, retry_cnt=0, mult_reg=MULTI_FAC-1, counters=0, lock sync flops=0.
- pll_lock goes through a 2-flop synchronizer (lock_s); all lock decisions use lock_s.
- RST_HOLD: pll_rst=1; count RST_CYCLES cycles, then CFG_WR with idx=0. The PLL clears its MD address pointer while in reset; the sequencer relies on this.
- CFG_WR (1 cycle): md_opc=01, md_wdi=table[idx]; table = {mult_reg, IDIV-1, ODIV-1}. Next state CFG_INC.
- CFG_INC (1 cycle): md_opc=00, md_ainc=1, md_wdi held. If idx==2, go to RELEASE; else idx++ and go to CFG_WR. A full programming pass is exactly 6 cycles.
- RELEASE (1 cycle): pll_rst=0; clear timeout and stable counters. Next state WAIT_LOCK.
- WAIT_LOCK: stable counter increments while lock_s=1 and clears to 0 when lock_s=0. The timeout counter increments every cycle.
  - When stable reaches LOCK_STABLE, go to LOCKED, set lock=1, retry_cnt=0.
  - Else, when timeout reaches LOCK_TIMEOUT: if retry_cnt<MAX_RETRY, retry_cnt++ and go to RST_HOLD; otherwise go to FAIL.
  - If stable and timeout complete on the same cycle, lock wins.
- LOCKED: lock=1, busy=0.
  - If lock_s falls, lock=0 on the next edge, go to RST_HOLD, and leave retry_cnt unchanged.
  - Else, if reconf_req=1: latch reconf_mult into mult_reg, pulse reconf_ack, set lock=0, go to RST_HOLD.
  - If lock loss and request occur together, lock loss wins; the request stays pending and is not acked.
- FAIL: fail=1, pll_rst=1, lock=0, busy=0. Only reconf_req exits FAIL: latch mult, ack, clear retry_cnt, go to RST_HOLD.
- reconf_req in any other state is neither acked nor latched and stays pending. Requester holds reconf_req/reconf_mult until ack and deasserts the cycle after. A req still high the cycle after ack counts as a new request.
- md_opc/md_ainc are registered outputs. Never both WRITE and ainc in the same cycle. Outside CFG_WR/CFG_INC: md_opc=00, md_ainc=0.
- Reset asserted mid-programming aborts immediately. The PLL is re-held in reset, so any partial writes are discarded.

Test Plan:
- Defaults with RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=100; pll_lock=1 from t0 -> pll_rst high 4 cycles; writes 0x1D,0x00,0x01 each followed by one ainc; pll_rst falls; lock rises 8 cycles after lock_s, i.e. +2 sync cycles.
- pll_lock stuck 0, MAX_RETRY=2 -> two full reprogram passes (retry_cnt 1, 2), third timeout enters FAIL. Checks: fail=1, pll_rst=1, busy=0, retry_cnt=2.
- In LOCKED, raise reconf_req with reconf_mult=0x13 -> single-cycle ack, lock drops next edge, addr0 write of 0x13, relock; hold req one extra cycle -> second reconfiguration occurs.
- In LOCKED, pulse pll_lock low for 1 cycle -> lock=0, full reprogram with unchanged mult; lock glitching at count 7 of 8 -> stable restarts, no lock.
- In FAIL, reconf_req mult=0x1D -> ack, retry_cnt=0, successful lock. reconf_req during WAIT_LOCK -> no ack until LOCKED.
- Assert reset during CFG_WR idx=1 -> all outputs at reset values asynchronously; after release, sequence restarts from idx 0 with mult_reg=0x1D.
